wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 84 ++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: one pipeline register in front of a 16x16 register file,
// with a bypass of the pending write onto both read ports and a retire counter.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_rd,
    input  logic        in_rw,
    input  logic        stall,
    input  logic [3:0]  ra1,
    input  logic [3:0]  ra2,
    output logic [15:0] rd1,
    output logic [15:0] rd2,
    output logic        wb_valid,
    output logic [3:0]  wb_rd,
    output logic [15:0] wb_data,
    output logic [15:0] retired
);

    logic        heldRw;
    logic [15:0] regFile [16];
    logic        commit;
    logic        writeEn;

    // Reset has priority in every register below, so a commit is simply a held entry with no stall.
    assign commit  = wb_valid && !stall;
    assign writeEn = commit && heldRw && (wb_rd != 4'd0);

    // Stage register: captures every unstalled cycle, bubbles included.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            heldRw   <= 1'b0;
        end else if (!stall) begin
            wb_valid <= in_valid;
            wb_rd    <= in_rd;
            wb_data  <= in_data;
            heldRw   <= in_rw;
        end
    end

    // Retire counter wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= '0;
        end else if (commit) begin
            retired <= retired + 16'd1;
        end
    end

    // Register file: the held entry is written as it commits; R0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regFile[i] <= '0;
            end
        end else if (writeEn) begin
            regFile[wb_rd] <= wb_data;
        end
    end

    // Read ports: R0 first, then the pending write, then the array.
    always_comb begin
        rd1 = regFile[ra1];
        if (ra1 == 4'd0) begin
            rd1 = '0;
        end else if (wb_valid && heldRw && (ra1 == wb_rd)) begin
            rd1 = wb_data;
        end
    end

    always_comb begin
        rd2 = regFile[ra2];
        if (ra2 == 4'd0) begin
            rd2 = '0;
        end else if (wb_valid && heldRw && (ra2 == wb_rd)) begin
            rd2 = wb_data;
        end
    end

endmodule
